// File: rtl/frame_ring_buffer.sv
// Single-clock ring of NUM_BUFFERS frame banks: the producer fills and commits banks,
// the consumer reads the oldest committed bank by address and releases it.
module frame_ring_buffer #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDRESS_WIDTH    = 9,
    parameter int NUM_BUFFERS      = 3,
    parameter int DROP_COUNT_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             writeEnable,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    output logic                             full,
    output logic                             oneWriteLeft,
    input  logic                             switchBuffer,
    output logic                             commitDropped,
    input  logic [ADDRESS_WIDTH-1:0]         readPointer,
    output logic [DATA_WIDTH-1:0]            dataOut,
    output logic [ADDRESS_WIDTH:0]           dataLength,
    output logic                             newData,
    // `release` is a reserved word, hence the longer name.
    input  logic                             releaseFrame,
    output logic [$clog2(NUM_BUFFERS)-1:0]   pendingFrames,
    output logic [DROP_COUNT_WIDTH-1:0]      droppedFrames
);

    localparam int DEPTH      = 1 << ADDRESS_WIDTH;
    localparam int BANK_WIDTH = $clog2(NUM_BUFFERS);
    localparam int COUNT_WIDTH = ADDRESS_WIDTH + 1;

    localparam logic [BANK_WIDTH-1:0]       LAST_BANK      = BANK_WIDTH'(NUM_BUFFERS - 1);
    localparam logic [COUNT_WIDTH-1:0]      FULL_COUNT     = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0]      ONE_LEFT_COUNT = COUNT_WIDTH'(DEPTH - 1);
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX       = '1;

    if (NUM_BUFFERS < 2) begin : gBadBufferCount
        $error("frame_ring_buffer: NUM_BUFFERS must be at least 2");
    end
    if (ADDRESS_WIDTH < 1) begin : gBadAddressWidth
        $error("frame_ring_buffer: ADDRESS_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0]  memory [NUM_BUFFERS][DEPTH];
    logic [COUNT_WIDTH-1:0] frameLengths [NUM_BUFFERS];

    logic [BANK_WIDTH-1:0]  writeBank;
    logic [BANK_WIDTH-1:0]  headBank;
    logic [BANK_WIDTH-1:0]  pendingCount;
    logic [COUNT_WIDTH-1:0] writeCount;

    logic                   writeAccepted;
    logic                   releaseAccepted;
    logic                   commitRequested;
    logic                   commitAccepted;
    logic                   commitRejected;
    logic [BANK_WIDTH-1:0]  pendingAfterRelease;
    logic [COUNT_WIDTH-1:0] committedLength;

    function automatic logic [BANK_WIDTH-1:0] nextBank(input logic [BANK_WIDTH-1:0] bank);
        return (bank == LAST_BANK) ? '0 : bank + BANK_WIDTH'(1);
    endfunction

    // Release is resolved before commit so a full ring can accept a frame on the
    // same edge that frees its head bank.
    always_comb begin
        writeAccepted       = writeEnable && !full;
        releaseAccepted     = releaseFrame && newData;
        commitRequested     = switchBuffer && (writeCount != '0);
        pendingAfterRelease = pendingCount - BANK_WIDTH'(releaseAccepted);
        commitAccepted      = commitRequested && (pendingAfterRelease < LAST_BANK);
        commitRejected      = commitRequested && !commitAccepted;
        committedLength     = writeCount + COUNT_WIDTH'(writeAccepted);
    end

    assign full          = (writeCount == FULL_COUNT);
    assign oneWriteLeft  = (writeCount == ONE_LEFT_COUNT);
    assign newData       = (pendingCount != '0);
    assign dataLength    = newData ? frameLengths[headBank] : '0;
    assign pendingFrames = pendingCount;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order the always blocks are evaluated in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writeBank     <= '0;
            headBank      <= '0;
            pendingCount  <= '0;
            writeCount    <= '0;
            commitDropped <= 1'b0;
            droppedFrames <= '0;
        end else begin
            commitDropped <= commitRejected;
            pendingCount  <= pendingAfterRelease + BANK_WIDTH'(commitAccepted);

            if (releaseAccepted) begin
                headBank <= nextBank(headBank);
            end

            if (commitAccepted) begin
                writeBank <= nextBank(writeBank);
            end

            // A dropped commit also restarts the bank, so it is simply rewritten.
            if (commitRequested) begin
                writeCount <= '0;
            end else if (writeAccepted) begin
                writeCount <= writeCount + COUNT_WIDTH'(1);
            end

            if (commitRejected && (droppedFrames != DROP_MAX)) begin
                droppedFrames <= droppedFrames + DROP_COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                frameLengths[i] <= '0;
            end
        end else if (commitAccepted) begin
            frameLengths[writeBank] <= committedLength;
        end
    end

    // NOTE: the frame storage has no reset so it can map onto block RAM; the
    // bookkeeping above is what makes its stale contents unreachable after reset.
    always_ff @(posedge clock) begin
        if (writeAccepted) begin
            memory[writeBank][writeCount[ADDRESS_WIDTH-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataOut <= '0;
        end else begin
            dataOut <= memory[headBank][readPointer];
        end
    end

endmodule

// File: tb/tb_frame_ring_buffer.sv
// Self-checking bench for frame_ring_buffer: directed scenarios plus randomized
// traffic compared against a queue-of-frames reference model.
module tb_frame_ring_buffer;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int NB    = 3;
    localparam int DCW   = 3;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          writeEnable;
    logic [DW-1:0] dataIn;
    logic          full;
    logic          oneWriteLeft;
    logic          switchBuffer;
    logic          commitDropped;
    logic [AW-1:0] readPointer;
    logic [DW-1:0] dataOut;
    logic [AW:0]   dataLength;
    logic          newData;
    logic          releaseFrame;
    logic [1:0]    pendingFrames;
    logic [DCW-1:0] droppedFrames;

    int errors = 0;
    int checks = 0;

    // Reference model: committed frames as a FIFO of (packed words, length).
    logic [DEPTH*DW-1:0] modelWords[$];
    int                  modelLens[$];
    logic [DEPTH*DW-1:0] curWords;
    int                  curLen;
    int                  modelDrops;
    bit                  expPulse;
    bit                  expReadValid;
    logic [DW-1:0]       expReadWord;

    frame_ring_buffer #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .NUM_BUFFERS(NB),
        .DROP_COUNT_WIDTH(DCW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .writeEnable(writeEnable),
        .dataIn(dataIn),
        .full(full),
        .oneWriteLeft(oneWriteLeft),
        .switchBuffer(switchBuffer),
        .commitDropped(commitDropped),
        .readPointer(readPointer),
        .dataOut(dataOut),
        .dataLength(dataLength),
        .newData(newData),
        .releaseFrame(releaseFrame),
        .pendingFrames(pendingFrames),
        .droppedFrames(droppedFrames)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic modelReset();
        modelWords.delete();
        modelLens.delete();
        curWords     = '0;
        curLen       = 0;
        modelDrops   = 0;
        expPulse     = 1'b0;
        expReadValid = 1'b0;
    endtask

    task automatic driveIdle();
        writeEnable  = 1'b0;
        dataIn       = '0;
        switchBuffer = 1'b0;
        readPointer  = '0;
        releaseFrame = 1'b0;
    endtask

    // Drives one clock of stimulus (called at a falling edge), updates the model,
    // and returns at the next falling edge where outputs are sampled.
    task automatic cycle(input logic we, input logic [DW-1:0] din, input logic sw,
                         input logic [AW-1:0] rp, input logic rel);
        logic [DEPTH*DW-1:0] headWords;
        bit wasEmpty;
        writeEnable  = we;
        dataIn       = din;
        switchBuffer = sw;
        readPointer  = rp;
        releaseFrame = rel;

        expReadValid = 1'b0;
        if (modelLens.size() != 0) begin
            if (int'(rp) < modelLens[0]) begin
                expReadValid = 1'b1;
                headWords    = modelWords[0];
                expReadWord  = headWords[int'(rp)*DW +: DW];
            end
        end

        if (rel && modelLens.size() != 0) begin
            void'(modelWords.pop_front());
            void'(modelLens.pop_front());
        end
        wasEmpty = (curLen == 0);
        if (we && curLen < DEPTH) begin
            curWords[curLen*DW +: DW] = din;
            curLen++;
        end
        expPulse = 1'b0;
        if (sw && !wasEmpty) begin
            if (modelLens.size() < NB - 1) begin
                modelWords.push_back(curWords);
                modelLens.push_back(curLen);
            end else begin
                expPulse = 1'b1;
                if (modelDrops < (1 << DCW) - 1) modelDrops++;
            end
            curLen   = 0;
            curWords = '0;
        end

        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        driveIdle();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (oneWriteLeft !== 1'b0) begin errors++; $display("FAIL reset_oneWriteLeft: got %b want 0", oneWriteLeft); end
        checks++; if (commitDropped !== 1'b0) begin errors++; $display("FAIL reset_commitDropped: got %b want 0", commitDropped); end
        checks++; if (dataOut !== '0) begin errors++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
        checks++; if (dataLength !== '0) begin errors++; $display("FAIL reset_dataLength: got %0d want 0", dataLength); end
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL reset_newData: got %b want 0", newData); end
        checks++; if (pendingFrames !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pendingFrames); end
        checks++; if (droppedFrames !== '0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", droppedFrames); end
        reset = 1'b0;
        modelReset();
        cycle(0, 0, 1, 0, 0);
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL empty_commit_newData: got %b want 0", newData); end
        checks++; if (pendingFrames !== '0) begin errors++; $display("FAIL empty_commit_pending: got %0d want 0", pendingFrames); end
        checks++; if (commitDropped !== 1'b0) begin errors++; $display("FAIL empty_commit_pulse: got %b want 0", commitDropped); end
    endtask

    task automatic test_single_frame();
        cycle(1, 4'h4, 0, 0, 0);
        cycle(1, 4'h5, 0, 0, 0);
        cycle(1, 4'h6, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++; if (newData !== 1'b1) begin errors++; $display("FAIL single_newData: got %b want 1", newData); end
        checks++; if (dataLength !== 3'd3) begin errors++; $display("FAIL single_length: got %0d want 3", dataLength); end
        checks++; if (pendingFrames !== 2'd1) begin errors++; $display("FAIL single_pending: got %0d want 1", pendingFrames); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h4) begin errors++; $display("FAIL single_read0: got %h want 4", dataOut); end
        cycle(0, 0, 0, 2'd1, 0);
        checks++; if (dataOut !== 4'h5) begin errors++; $display("FAIL single_read1: got %h want 5", dataOut); end
        cycle(0, 0, 0, 2'd2, 0);
        checks++; if (dataOut !== 4'h6) begin errors++; $display("FAIL single_read2: got %h want 6", dataOut); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL single_release_newData: got %b want 0", newData); end
        checks++; if (dataLength !== 3'd0) begin errors++; $display("FAIL single_release_length: got %0d want 0", dataLength); end
    endtask

    task automatic test_full_depth();
        cycle(1, 4'h1, 0, 0, 0);
        cycle(1, 4'h2, 0, 0, 0);
        cycle(1, 4'h3, 0, 0, 0);
        checks++; if (oneWriteLeft !== 1'b1) begin errors++; $display("FAIL depth_oneLeft: got %b want 1", oneWriteLeft); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL depth_notFull: got %b want 0", full); end
        cycle(1, 4'h4, 0, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL depth_full: got %b want 1", full); end
        checks++; if (oneWriteLeft !== 1'b0) begin errors++; $display("FAIL depth_oneLeftClear: got %b want 0", oneWriteLeft); end
        cycle(1, 4'h9, 0, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL depth_fullHeld: got %b want 1", full); end
        cycle(0, 0, 1, 0, 0);
        checks++; if (dataLength !== 3'd4) begin errors++; $display("FAIL depth_length: got %0d want 4", dataLength); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL depth_fullAfterCommit: got %b want 0", full); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h1) begin errors++; $display("FAIL depth_read0: got %h want 1", dataOut); end
        cycle(0, 0, 0, 2'd3, 0);
        checks++; if (dataOut !== 4'h4) begin errors++; $display("FAIL depth_read3: got %h want 4", dataOut); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL depth_release: got %b want 0", newData); end
    endtask

    task automatic test_drop();
        cycle(1, 4'h8, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 4'h9, 0, 0, 0);
        cycle(1, 4'ha, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++; if (pendingFrames !== 2'd2) begin errors++; $display("FAIL drop_pending2: got %0d want 2", pendingFrames); end
        checks++; if (commitDropped !== 1'b0) begin errors++; $display("FAIL drop_noPulse: got %b want 0", commitDropped); end
        cycle(1, 4'hc, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++; if (commitDropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", commitDropped); end
        checks++; if (droppedFrames !== 3'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", droppedFrames); end
        checks++; if (pendingFrames !== 2'd2) begin errors++; $display("FAIL drop_pendingHeld: got %0d want 2", pendingFrames); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (commitDropped !== 1'b0) begin errors++; $display("FAIL drop_pulseWidth: got %b want 0", commitDropped); end
        checks++; if (dataOut !== 4'h8) begin errors++; $display("FAIL drop_readA: got %h want 8", dataOut); end
        checks++; if (dataLength !== 3'd1) begin errors++; $display("FAIL drop_lengthA: got %0d want 1", dataLength); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (dataLength !== 3'd2) begin errors++; $display("FAIL drop_lengthB: got %0d want 2", dataLength); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h9) begin errors++; $display("FAIL drop_readB0: got %h want 9", dataOut); end
        cycle(0, 0, 0, 2'd1, 0);
        checks++; if (dataOut !== 4'ha) begin errors++; $display("FAIL drop_readB1: got %h want a", dataOut); end
    endtask

    task automatic test_same_edge();
        cycle(1, 4'h5, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++; if (pendingFrames !== 2'd2) begin errors++; $display("FAIL same_pendingBefore: got %0d want 2", pendingFrames); end
        cycle(1, 4'h7, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);
        checks++; if (pendingFrames !== 2'd2) begin errors++; $display("FAIL same_pending: got %0d want 2", pendingFrames); end
        checks++; if (commitDropped !== 1'b0) begin errors++; $display("FAIL same_pulse: got %b want 0", commitDropped); end
        checks++; if (droppedFrames !== 3'd1) begin errors++; $display("FAIL same_dropped: got %0d want 1", droppedFrames); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h5) begin errors++; $display("FAIL same_readD: got %h want 5", dataOut); end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h7) begin errors++; $display("FAIL same_readKept: got %h want 7", dataOut); end
        checks++; if (pendingFrames !== 2'd1) begin errors++; $display("FAIL same_pendingAfter: got %0d want 1", pendingFrames); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL same_drained: got %b want 0", newData); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 4'h3, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 4'h1, 0, 0, 0);
        driveIdle();
        #2 reset = 1'b1;
        #1;
        checks++; if (newData !== 1'b0) begin errors++; $display("FAIL midreset_newData: got %b want 0", newData); end
        checks++; if (pendingFrames !== '0) begin errors++; $display("FAIL midreset_pending: got %0d want 0", pendingFrames); end
        checks++; if (dataLength !== '0) begin errors++; $display("FAIL midreset_length: got %0d want 0", dataLength); end
        checks++; if (dataOut !== '0) begin errors++; $display("FAIL midreset_dataOut: got %h want 0", dataOut); end
        checks++; if (droppedFrames !== '0) begin errors++; $display("FAIL midreset_dropped: got %0d want 0", droppedFrames); end
        checks++; if ({full, oneWriteLeft, commitDropped} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b want 000", {full, oneWriteLeft, commitDropped}); end
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        cycle(1, 4'h6, 0, 0, 0);
        cycle(1, 4'h2, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++; if (newData !== 1'b1) begin errors++; $display("FAIL postreset_newData: got %b want 1", newData); end
        checks++; if (dataLength !== 3'd2) begin errors++; $display("FAIL postreset_length: got %0d want 2", dataLength); end
        checks++; if (pendingFrames !== 2'd1) begin errors++; $display("FAIL postreset_pending: got %0d want 1", pendingFrames); end
        cycle(0, 0, 0, 2'd0, 0);
        checks++; if (dataOut !== 4'h6) begin errors++; $display("FAIL postreset_read0: got %h want 6", dataOut); end
        cycle(0, 0, 0, 2'd1, 0);
        checks++; if (dataOut !== 4'h2) begin errors++; $display("FAIL postreset_read1: got %h want 2", dataOut); end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        driveIdle();
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        for (int n = 0; n < 2500; n++) begin
            cycle($urandom_range(0, 99) < 60, DW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 25, AW'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 12);
            checks++; if (newData !== (modelLens.size() != 0)) begin errors++; $display("FAIL rand_newData @%0d: got %b want %b", n, newData, modelLens.size() != 0); end
            checks++; if (dataLength !== ((modelLens.size() != 0) ? 3'(modelLens[0]) : 3'd0)) begin errors++; $display("FAIL rand_length @%0d: got %0d", n, dataLength); end
            checks++; if (pendingFrames !== 2'(modelLens.size())) begin errors++; $display("FAIL rand_pending @%0d: got %0d want %0d", n, pendingFrames, modelLens.size()); end
            checks++; if (full !== (curLen == DEPTH)) begin errors++; $display("FAIL rand_full @%0d: got %b want %b", n, full, curLen == DEPTH); end
            checks++; if (oneWriteLeft !== (curLen == DEPTH - 1)) begin errors++; $display("FAIL rand_oneLeft @%0d: got %b want %b", n, oneWriteLeft, curLen == DEPTH - 1); end
            checks++; if (commitDropped !== expPulse) begin errors++; $display("FAIL rand_pulse @%0d: got %b want %b", n, commitDropped, expPulse); end
            checks++; if (droppedFrames !== 3'(modelDrops)) begin errors++; $display("FAIL rand_dropped @%0d: got %0d want %0d", n, droppedFrames, modelDrops); end
            if (expReadValid) begin
                checks++; if (dataOut !== expReadWord) begin errors++; $display("FAIL rand_dataOut @%0d: got %h want %h", n, dataOut, expReadWord); end
            end
        end
        driveIdle();
    endtask

    initial begin
        driveIdle();
        modelReset();
        test_reset();
        test_single_frame();
        test_full_depth();
        test_drop();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
